// File: rtl/sparc_muldiv_unit_pkg.sv
// Shared definitions for the iterative SPARC V8 multiply/divide unit:
// operation codes, FSM state encoding and ICC bit positions used by the PSR logic.
package sparc_muldiv_unit_pkg;

    localparam logic [1:0] MD_UMUL = 2'b00;
    localparam logic [1:0] MD_SMUL = 2'b01;
    localparam logic [1:0] MD_UDIV = 2'b10;
    localparam logic [1:0] MD_SDIV = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam int ICC_N = 3;
    localparam int ICC_Z = 2;
    localparam int ICC_V = 1;
    localparam int ICC_C = 0;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/sparc_muldiv_unit_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract
// for divide. acc is the product high half or the partial remainder.
module sparc_muldiv_unit_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, d} : '0);
        shifted = {acc, q[WIDTH-1]};
        ge      = (shifted >= {1'b0, d});
        // Remainder stays below the divisor, so the low WIDTH bits of the difference are exact.
        diff    = shifted[WIDTH-1:0] - d;
        if (is_div) begin
            acc_next = ge ? diff : shifted[WIDTH-1:0];
            q_next   = {q[WIDTH-2:0], ge};
        end else begin
            acc_next = sum[WIDTH:1];
            q_next   = {sum[0], q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/sparc_muldiv_unit.sv
// Iterative UMUL/SMUL/UDIV/SDIV unit: FSM, iteration counter and sign/overflow fix-up.
// Handshake: start is accepted only in IDLE; busy covers CALC and FIX; done pulses once with results.
module sparc_muldiv_unit
    import sparc_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEPS = 1
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] Y_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] Y_out,
    output logic [3:0]       icc,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    localparam int ITERS = WIDTH / STEPS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    md_state_t        state;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] acc_q, q_q, d_q, y_q;
    logic             neg_q, ovf_q;
    logic [CNT_W-1:0] cnt_q;

    // Operand conditioning at start: magnitudes, result sign and early divide overflow.
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0]   ld_acc, ld_q, ld_d;
    logic               ld_neg, ld_ovf;

    always_comb begin
        a_mag   = A[WIDTH-1] ? -A : A;
        b_mag   = B[WIDTH-1] ? -B : B;
        dvd_mag = Y_in[WIDTH-1] ? -{Y_in, A} : {Y_in, A};
        ld_acc  = '0;
        ld_q    = A;
        ld_d    = B;
        ld_neg  = 1'b0;
        ld_ovf  = 1'b0;
        case (op)
            MD_SMUL: begin
                ld_q   = a_mag;
                ld_d   = b_mag;
                ld_neg = A[WIDTH-1] ^ B[WIDTH-1];
            end
            MD_UDIV: begin
                ld_acc = Y_in;
                ld_ovf = (Y_in >= B);
            end
            MD_SDIV: begin
                ld_acc = dvd_mag[2*WIDTH-1:WIDTH];
                ld_q   = dvd_mag[WIDTH-1:0];
                ld_d   = b_mag;
                ld_neg = Y_in[WIDTH-1] ^ B[WIDTH-1];
                ld_ovf = (dvd_mag[2*WIDTH-1:WIDTH] >= b_mag);
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < STEPS; i++) begin : g_step
        logic [WIDTH-1:0] acc_in, q_in, acc_out, q_out;
        if (i == 0) begin : g_first
            assign acc_in = acc_q;
            assign q_in   = q_q;
        end else begin : g_next
            assign acc_in = g_step[i-1].acc_out;
            assign q_in   = g_step[i-1].q_out;
        end
        sparc_muldiv_unit_step #(.WIDTH(WIDTH)) u_step (
            .is_div  (op_is_div(op_q)),
            .acc     (acc_in),
            .q       (q_in),
            .d       (d_q),
            .acc_next(acc_out),
            .q_next  (q_out)
        );
    end

    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   fix_res, fix_y;
    logic               fix_v;
    logic [3:0]         fix_icc;

    always_comb begin
        prod_s  = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
        fix_res = prod_s[WIDTH-1:0];
        fix_y   = prod_s[2*WIDTH-1:WIDTH];
        fix_v   = 1'b0;
        case (op_q)
            MD_UDIV: begin
                fix_v   = ovf_q;
                fix_res = ovf_q ? '1 : q_q;
                fix_y   = y_q;
            end
            MD_SDIV: begin
                // A negative quotient may reach the most-negative value; a positive one may not.
                fix_v   = ovf_q | (neg_q ? (q_q > MOST_NEG) : q_q[WIDTH-1]);
                fix_res = fix_v ? (neg_q ? MOST_NEG : ~MOST_NEG) : (neg_q ? -q_q : q_q);
                fix_y   = y_q;
            end
            default: ;
        endcase
        fix_icc        = '0;
        fix_icc[ICC_N] = fix_res[WIDTH-1];
        fix_icc[ICC_Z] = (fix_res == '0);
        fix_icc[ICC_V] = fix_v;
        fix_icc[ICC_C] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            state    <= MD_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
            Y_out    <= '0;
            icc      <= '0;
            op_q     <= MD_UMUL;
            acc_q    <= '0;
            q_q      <= '0;
            d_q      <= '0;
            y_q      <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state)
                MD_IDLE: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    if (start) begin
                        if (op_is_div(op) && (B == '0)) begin
                            state    <= MD_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state <= MD_CALC;
                            busy  <= 1'b1;
                            op_q  <= op;
                            acc_q <= ld_acc;
                            q_q   <= ld_q;
                            d_q   <= ld_d;
                            y_q   <= Y_in;
                            neg_q <= ld_neg;
                            ovf_q <= ld_ovf;
                            cnt_q <= CNT_W'(ITERS);
                        end
                    end
                end
                MD_CALC: begin
                    acc_q <= g_step[STEPS-1].acc_out;
                    q_q   <= g_step[STEPS-1].q_out;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) state <= MD_FIX;
                end
                MD_FIX: begin
                    result <= fix_res;
                    Y_out  <= fix_y;
                    icc    <= fix_icc;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    state  <= MD_DONE;
                end
                default: begin
                    done     <= 1'b0;
                    div_zero <= 1'b0;
                    state    <= MD_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_sparc_muldiv_unit.sv
// Directed bench for sparc_muldiv_unit: vector table for all four ops plus
// hand sequences for reset abort, Clr/start collision and the STEPS=4 variant.
module tb_sparc_muldiv_unit;
    import sparc_muldiv_unit_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, y;
        logic [31:0] res, yo;
        logic [3:0]  icc;
        logic        dz;
        int          lat;
    } vec_t;

    logic        clk, clr;
    logic        start, start4;
    logic [1:0]  op, op4;
    logic [31:0] a, b, y_in, a4, b4, y4;
    logic        busy, done, div_zero, busy4, done4, div_zero4;
    logic [31:0] result, y_out, result4, y_out4;
    logic [3:0]  icc, icc4;
    logic [1:0]  dbg_state, dbg_state4;

    int pass_cnt = 0;
    int total_cnt = 0;
    vec_t vecs[16];

    sparc_muldiv_unit dut (
        .Clk(clk), .Clr(clr), .start(start), .op(op), .A(a), .B(b), .Y_in(y_in),
        .busy(busy), .done(done), .result(result), .Y_out(y_out), .icc(icc),
        .div_zero(div_zero), .dbg_state(dbg_state)
    );

    sparc_muldiv_unit #(.WIDTH(32), .STEPS(4)) dut4 (
        .Clk(clk), .Clr(clr), .start(start4), .op(op4), .A(a4), .B(b4), .Y_in(y4),
        .busy(busy4), .done(done4), .result(result4), .Y_out(y_out4), .icc(icc4),
        .div_zero(div_zero4), .dbg_state(dbg_state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        @(negedge clk);
        op = v.op; a = v.a; b = v.b; y_in = v.y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op = 2'($urandom_range(0, 3)); a = $urandom; b = $urandom; y_in = $urandom;
        cyc = 1;
        check($sformatf("v%0d busy", idx), 64'(busy), 64'(!v.dz));
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check($sformatf("v%0d latency", idx), 64'(cyc), 64'(v.lat));
        check($sformatf("v%0d result", idx), 64'(result), 64'(v.res));
        check($sformatf("v%0d y_out", idx), 64'(y_out), 64'(v.yo));
        check($sformatf("v%0d icc", idx), 64'(icc), 64'(v.icc));
        check($sformatf("v%0d div_zero", idx), 64'(div_zero), 64'(v.dz));
        @(negedge clk);
        check($sformatf("v%0d done pulse", idx), 64'(done), 64'(0));
    endtask

    initial begin
        int cyc;
        int extra;
        vecs[0]  = '{MD_UMUL, 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 32'h1, 4'h8, 1'b0, 34};
        vecs[1]  = '{MD_SMUL, 32'hFFFFFFFD, 32'd5, 32'd0, 32'hFFFFFFF1, 32'hFFFFFFFF, 4'h8, 1'b0, 34};
        vecs[2]  = '{MD_UDIV, 32'd100, 32'd7, 32'd0, 32'd14, 32'd0, 4'h0, 1'b0, 34};
        vecs[3]  = '{MD_UDIV, 32'd0, 32'd7, 32'd8, 32'hFFFFFFFF, 32'd8, 4'hA, 1'b0, 34};
        vecs[4]  = '{MD_SDIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFF2, 32'hFFFFFFFF, 4'h8, 1'b0, 34};
        vecs[5]  = '{MD_SDIV, 32'h80000000, 32'd1, 32'd0, 32'h7FFFFFFF, 32'd0, 4'h2, 1'b0, 34};
        vecs[6]  = '{MD_UDIV, 32'd9, 32'd0, 32'd5, 32'h7FFFFFFF, 32'd0, 4'h2, 1'b1, 1};
        vecs[7]  = '{MD_SMUL, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 32'h40000000, 4'h4, 1'b0, 34};
        vecs[8]  = '{MD_SDIV, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 4'h8, 1'b0, 34};
        vecs[9]  = '{MD_SDIV, 32'd2, 32'd0, 32'd1, 32'h80000000, 32'hFFFFFFFF, 4'h8, 1'b1, 1};
        vecs[10] = '{MD_SDIV, 32'd100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF2, 32'd0, 4'h8, 1'b0, 34};
        vecs[11] = '{MD_SDIV, 32'h7FFFFFFF, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 4'hA, 1'b0, 34};
        vecs[12] = '{MD_SMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 4'h0, 1'b0, 34};
        vecs[13] = '{MD_SDIV, 32'd0, 32'd7, 32'd7, 32'h7FFFFFFF, 32'd7, 4'h2, 1'b0, 34};
        vecs[14] = '{MD_UMUL, 32'd0, 32'd12345, 32'd0, 32'd0, 32'd0, 4'h4, 1'b0, 34};
        vecs[15] = '{MD_UDIV, 32'd0, 32'd2, 32'd1, 32'h80000000, 32'd1, 4'h8, 1'b0, 34};

        clr = 1'b1; start = 1'b0; start4 = 1'b0;
        op = MD_UMUL; a = '0; b = '0; y_in = '0;
        op4 = MD_UMUL; a4 = '0; b4 = '0; y4 = '0;
        repeat (3) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        check("reset state", 64'(dbg_state), 64'(MD_IDLE));
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset div_zero", 64'(div_zero), 64'(0));
        check("reset result", 64'(result), 64'(0));
        check("reset y_out", 64'(y_out), 64'(0));
        check("reset icc", 64'(icc), 64'(0));
        check("reset4 done", 64'(done4), 64'(0));

        for (int i = 0; i < 16; i++) run_vec(vecs[i], i);

        // Clr at cycle 10 of a multiply: abort with reset values and no done pulse.
        @(negedge clk);
        op = MD_UMUL; a = 32'd3; b = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        check("clr state", 64'(dbg_state), 64'(MD_IDLE));
        check("clr busy", 64'(busy), 64'(0));
        check("clr result", 64'(result), 64'(0));
        check("clr y_out", 64'(y_out), 64'(0));
        check("clr icc", 64'(icc), 64'(0));
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("clr no done", 64'(extra), 64'(0));
        run_vec(vecs[0], 100);

        // Clr and start in the same cycle: the start is dropped.
        @(negedge clk);
        op = MD_UMUL; a = 32'd5; b = 32'd5; start = 1'b1; clr = 1'b1;
        @(negedge clk);
        start = 1'b0; clr = 1'b0;
        check("clr+start state", 64'(dbg_state), 64'(MD_IDLE));
        check("clr+start busy", 64'(busy), 64'(0));

        // STEPS=4 instance: 8 iterations, a second start while busy is ignored.
        @(negedge clk);
        op4 = MD_UMUL; a4 = 32'd1234; b4 = 32'd5678; y4 = '0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 1;
        check("s4 busy", 64'(busy4), 64'(1));
        while (!done4 && cyc < 100) begin
            if (cyc == 3) begin
                start4 = 1'b1; a4 = 32'd2; b4 = 32'd3;
            end else begin
                start4 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start4 = 1'b0;
        check("s4 latency", 64'(cyc), 64'(10));
        check("s4 result", 64'(result4), 64'(32'd7006652));
        check("s4 y_out", 64'(y_out4), 64'(0));
        check("s4 icc", 64'(icc4), 64'(0));
        extra = 0;
        repeat (15) begin
            @(negedge clk);
            if (done4) extra++;
        end
        check("s4 no extra done", 64'(extra), 64'(0));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
